// File: rtl/sum_acc_pkg.sv
// Shared definitions for the sum accumulator: state encoding and default sizing.
package sum_acc_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_e;

   localparam int unsigned DEF_N     = 8;
   localparam int unsigned DEF_ACC_W = 12;
   localparam int unsigned S_W       = 9;   // 8-bit adder result plus carry

endpackage

// File: rtl/sum_accumulator.sv
// Accumulates N unsigned 9-bit sums into one result, then holds it until the
// downstream takes it. A synchronous clear aborts the batch at any time.
// ACC_W must cover N*511 (ACC_W >= 9 + clog2(N)), so the adder never wraps.
module sum_accumulator
   import sum_acc_pkg::*;
#(
   parameter int unsigned N     = DEF_N,
   parameter int unsigned ACC_W = DEF_ACC_W,
   localparam int unsigned CNT_W = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [S_W-1:0]   s,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [ACC_W-1:0] acc,
   output logic [CNT_W-1:0] count,
   output logic             out_valid,
   input  logic             out_ready
);

   state_e           state_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             accept;
   logic             last;

   // Inline adder and counter; only used when a sum is accepted.
   always_comb begin
      accept = (state_q == ACCUM) && in_valid;
      acc_d  = acc_q + {{(ACC_W - S_W){1'b0}}, s};
      cnt_d  = cnt_q + CNT_W'(1);
      last   = (cnt_q == CNT_W'(N - 1));
   end

   // Batch FSM: clear beats everything, then acceptance / result hand-off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else if (clear) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (accept) begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_d;
                  if (last) state_q <= DONE;
               end
            end
            DONE: begin
               // Input is ignored here, including in the hand-off cycle.
               if (out_ready) begin
                  state_q <= ACCUM;
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   // Handshake flags decode straight from the state register.
   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == DONE);
   assign acc       = acc_q;
   assign count     = cnt_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed testbench for sum_accumulator with default N=8, ACC_W=12.
module tb_sum_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic [8:0]  s;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] acc;
   logic [3:0]  count;
   logic        out_valid;
   logic        out_ready;

   int nchk = 0;
   int nerr = 0;

   sum_accumulator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .s         (s),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .acc       (acc),
      .count     (count),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
   task automatic cyc(input logic v, input logic [8:0] sv, input logic ordy, input logic clr);
      @(negedge clk);
      in_valid  = v;
      s         = sv;
      out_ready = ordy;
      clear     = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clear = 1'b0; s = '0; in_valid = 1'b0; out_ready = 1'b0;
      #3;
      nchk++; if (acc !== 12'h000) begin nerr++; $display("FAIL reset_acc: got %0h want 000", acc); end
      nchk++; if (count !== 4'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", count); end
      nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_full_scale();
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 9'h1FE, 1'b0, 1'b0);
         nchk++; if (count !== 4'(i)) begin nerr++; $display("FAIL full_count_%0d: got %0d want %0d", i, count, i); end
         nchk++; if (acc !== 12'(i * 510)) begin nerr++; $display("FAIL full_acc_%0d: got %0d want %0d", i, acc, i * 510); end
      end
      nchk++; if (acc !== 12'hFF0) begin nerr++; $display("FAIL full_final_acc: got %0h want FF0", acc); end
      nchk++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
      nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL full_in_ready: got %b want 0", in_ready); end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 9'h005, 1'b0, 1'b0);
         nchk++; if (acc !== 12'hFF0) begin nerr++; $display("FAIL bp_hold_acc_%0d: got %0h want FF0", i, acc); end
         nchk++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin nerr++;
            $display("FAIL bp_hold_flags_%0d: got in_ready=%b out_valid=%b want 0/1", i, in_ready, out_valid); end
         nchk++; if (count !== 4'd8) begin nerr++; $display("FAIL bp_hold_count_%0d: got %0d want 8", i, count); end
      end
      // Hand-off cycle: the concurrent input must not be taken.
      cyc(1'b1, 9'h005, 1'b1, 1'b0);
      nchk++; if (acc !== 12'h000) begin nerr++; $display("FAIL bp_drain_acc: got %0h want 000", acc); end
      nchk++; if (count !== 4'd0) begin nerr++; $display("FAIL bp_drain_count: got %0d want 0", count); end
      nchk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nerr++;
         $display("FAIL bp_drain_flags: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
   endtask

   task automatic test_gapped();
      int exp_acc;
      exp_acc = 0;
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 9'(i), 1'b0, 1'b0);
         exp_acc += i;
         nchk++; if (count !== 4'(i) || acc !== 12'(exp_acc)) begin nerr++;
            $display("FAIL gap_accept_%0d: got count=%0d acc=%0d want %0d/%0d", i, count, acc, i, exp_acc); end
         if (i < 8) begin
            cyc(1'b0, 9'h1FF, 1'b0, 1'b0);
            nchk++; if (count !== 4'(i) || acc !== 12'(exp_acc)) begin nerr++;
               $display("FAIL gap_idle_%0d: got count=%0d acc=%0d want %0d/%0d", i, count, acc, i, exp_acc); end
            nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL gap_early_valid_%0d: got %b want 0", i, out_valid); end
         end
      end
      nchk++; if (acc !== 12'd36 || out_valid !== 1'b1) begin nerr++;
         $display("FAIL gap_final: got acc=%0d out_valid=%b want 36/1", acc, out_valid); end
      cyc(1'b0, 9'h000, 1'b1, 1'b0);
   endtask

   task automatic test_clear();
      for (int i = 0; i < 3; i++) cyc(1'b1, 9'h001, 1'b0, 1'b0);
      nchk++; if (count !== 4'd3) begin nerr++; $display("FAIL clr_pre_count: got %0d want 3", count); end
      cyc(1'b1, 9'h100, 1'b0, 1'b1);
      nchk++; if (acc !== 12'h000 || count !== 4'd0) begin nerr++;
         $display("FAIL clr_drop: got acc=%0h count=%0d want 000/0", acc, count); end
      for (int i = 0; i < 8; i++) cyc(1'b1, 9'h001, 1'b0, 1'b0);
      nchk++; if (acc !== 12'd8 || out_valid !== 1'b1) begin nerr++;
         $display("FAIL clr_refill: got acc=%0d out_valid=%b want 8/1", acc, out_valid); end
   endtask

   task automatic test_clear_done();
      cyc(1'b0, 9'h000, 1'b0, 1'b1);
      nchk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nerr++;
         $display("FAIL clrdone_flags: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      nchk++; if (acc !== 12'h000 || count !== 4'd0) begin nerr++;
         $display("FAIL clrdone_state: got acc=%0h count=%0d want 000/0", acc, count); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) cyc(1'b1, 9'h00A, 1'b0, 1'b0);
      nchk++; if (count !== 4'd3 || acc !== 12'd30) begin nerr++;
         $display("FAIL rstmid_pre: got count=%0d acc=%0d want 3/30", count, acc); end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      nchk++; if (acc !== 12'h000 || count !== 4'd0 || out_valid !== 1'b0) begin nerr++;
         $display("FAIL rstmid_async: got acc=%0h count=%0d out_valid=%b want 000/0/0", acc, count, out_valid); end
      @(negedge clk); rst_n = 1'b1;
      cyc(1'b1, 9'h007, 1'b0, 1'b0);
      nchk++; if (acc !== 12'd7 || count !== 4'd1) begin nerr++;
         $display("FAIL rstmid_fresh: got acc=%0d count=%0d want 7/1", acc, count); end
   endtask

   initial begin
      test_reset();
      test_full_scale();
      test_backpressure();
      test_gapped();
      test_clear();
      test_clear_done();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
